w_cpu_io_stream_bridge: RTL and testbench

W_CPU_IO_STREAM_BRIDGE -- requirements
Module: w_cpu_io_stream_bridge

---
 rtl/w_cpu_io_pkg.sv | 36 +++
 rtl/w_cpu_io_res_collector.sv | 78 +++++++
 rtl/w_cpu_io_stream_bridge.sv | 112 +++++++++++
 tb/tb_w_cpu_io_stream_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/w_cpu_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : w_cpu_io_pkg
// Description : Shared state encodings, beat counts and control-bit indices
//               for the CPU <-> fabric nibble stream bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package w_cpu_io_pkg;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic [0:0] {
        RX_COLLECT = 1'b0,
        RX_HOLD    = 1'b1
    } rx_state_t;

    localparam int OP_BEATS   = 8;
    localparam int RES_BEATS  = 4;
    localparam int OP_BEAT_W  = $clog2(OP_BEATS);
    localparam int RES_BEAT_W = $clog2(RES_BEATS);

    localparam int OPB_OP_VALID  = 0;
    localparam int OPB_OP_FIRST  = 1;
    localparam int OPB_OP_LAST   = 2;
    localparam int OPB_RES_READY = 3;

    localparam int RES2_OP_ACK    = 0;
    localparam int RES2_RES_VALID = 1;
    localparam int RES2_RES_LAST  = 2;
    localparam int RES2_UNUSED    = 3;

endpackage
`default_nettype wire

// File: rtl/w_cpu_io_res_collector.sv
`default_nettype none
// ============================================================================
// Module      : w_cpu_io_res_collector
// Description : RX path - gathers byte beats from the fabric into a 32-bit
//               result word and holds it until the CPU takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module w_cpu_io_res_collector
    import w_cpu_io_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_res_valid,
    input  logic                   i_res_last,
    input  logic [7:0]             i_res_byte,
    output logic                   o_res_ready,
    input  logic                   i_cpu_ready,
    output logic [8*RES_BEATS-1:0] o_cpu_data,
    output logic                   o_cpu_valid,
    output logic                   o_cpu_err
);

    localparam logic [RES_BEAT_W-1:0] c_rbeat_last = RES_BEAT_W'(RES_BEATS - 1);

    rx_state_t              r_state;
    logic [RES_BEAT_W-1:0]  r_rbeat;
    logic [8*RES_BEATS-1:0] r_data;
    logic                   r_valid;
    logic                   r_err;
    logic                   r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_COLLECT;
            r_rbeat <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                RX_COLLECT: begin
                    r_ready <= 1'b1;
                    if (r_ready && i_res_valid) begin
                        r_data[{r_rbeat, 3'b000} +: 8] <= i_res_byte;
                        // A word ends on res_last or a full buffer; only both together is clean.
                        if (i_res_last || (r_rbeat == c_rbeat_last)) begin
                            r_state <= RX_HOLD;
                            r_valid <= 1'b1;
                            r_ready <= 1'b0;
                            r_err   <= !(i_res_last && (r_rbeat == c_rbeat_last));
                        end else begin
                            r_rbeat <= r_rbeat + 1'b1;
                        end
                    end
                end
                RX_HOLD: begin
                    if (i_cpu_ready) begin
                        r_state <= RX_COLLECT;
                        r_rbeat <= '0;
                        r_data  <= '0;
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= RX_COLLECT;
            endcase
        end
    end

    assign o_res_ready = r_ready;
    assign o_cpu_data  = r_data;
    assign o_cpu_valid = r_valid;
    assign o_cpu_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/w_cpu_io_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : w_cpu_io_stream_bridge
// Description : CPU word <-> fabric nibble/byte stream bridge with independent
//               TX (operand serialiser) and RX (result collector) paths.
// Revision    : 1.0 - initial release
// ============================================================================
module w_cpu_io_stream_bridge
    import w_cpu_io_pkg::*;
(
    input  logic        UserCLK,
    input  logic        reset,
    input  logic [31:0] cpu_op_data,
    input  logic        cpu_op_valid,
    output logic        cpu_op_ready,
    output logic [31:0] cpu_res_data,
    output logic        cpu_res_valid,
    input  logic        cpu_res_ready,
    output logic        cpu_res_err,
    output logic [3:0]  OPA_O,
    output logic [3:0]  OPB_O,
    input  logic [3:0]  RES0_I,
    input  logic [3:0]  RES1_I,
    input  logic [3:0]  RES2_I
);

    localparam logic [OP_BEAT_W-1:0] c_beat_last    = OP_BEAT_W'(OP_BEATS - 1);
    localparam logic [OP_BEAT_W-1:0] c_beat_prelast = OP_BEAT_W'(OP_BEATS - 2);

    tx_state_t              r_state;
    logic [4*OP_BEATS-1:0]  r_shift;
    logic [OP_BEAT_W-1:0]   r_beat;
    logic                   r_op_ready;
    logic                   r_op_valid;
    logic                   r_op_first;
    logic                   r_op_last;
    logic                   w_op_ack;
    logic                   w_res_ready;
    logic                   w_unused_res2;

    assign w_op_ack      = RES2_I[RES2_OP_ACK];
    assign w_unused_res2 = RES2_I[RES2_UNUSED];

    // Shift register is cleared on return to idle so OPA_O reads zero there.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            r_state    <= TX_IDLE;
            r_shift    <= '0;
            r_beat     <= '0;
            r_op_ready <= 1'b0;
            r_op_valid <= 1'b0;
            r_op_first <= 1'b0;
            r_op_last  <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_op_ready <= 1'b1;
                    if (r_op_ready && cpu_op_valid) begin
                        r_state    <= TX_SEND;
                        r_shift    <= cpu_op_data;
                        r_beat     <= '0;
                        r_op_ready <= 1'b0;
                        r_op_valid <= 1'b1;
                        r_op_first <= 1'b1;
                        r_op_last  <= 1'b0;
                    end
                end
                TX_SEND: begin
                    if (w_op_ack) begin
                        if (r_beat == c_beat_last) begin
                            r_state    <= TX_IDLE;
                            r_shift    <= '0;
                            r_beat     <= '0;
                            r_op_ready <= 1'b1;
                            r_op_valid <= 1'b0;
                            r_op_first <= 1'b0;
                            r_op_last  <= 1'b0;
                        end else begin
                            r_shift    <= r_shift >> 4;
                            r_beat     <= r_beat + 1'b1;
                            r_op_first <= 1'b0;
                            r_op_last  <= (r_beat == c_beat_prelast);
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    w_cpu_io_res_collector u_res_collector (
        .clk         (UserCLK),
        .rst         (reset),
        .i_res_valid (RES2_I[RES2_RES_VALID]),
        .i_res_last  (RES2_I[RES2_RES_LAST]),
        .i_res_byte  ({RES1_I, RES0_I}),
        .o_res_ready (w_res_ready),
        .i_cpu_ready (cpu_res_ready),
        .o_cpu_data  (cpu_res_data),
        .o_cpu_valid (cpu_res_valid),
        .o_cpu_err   (cpu_res_err)
    );

    assign cpu_op_ready         = r_op_ready;
    assign OPA_O                = r_shift[3:0];
    assign OPB_O[OPB_OP_VALID]  = r_op_valid;
    assign OPB_O[OPB_OP_FIRST]  = r_op_first;
    assign OPB_O[OPB_OP_LAST]   = r_op_last;
    assign OPB_O[OPB_RES_READY] = w_res_ready;

endmodule
`default_nettype wire

// File: tb/tb_w_cpu_io_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_w_cpu_io_stream_bridge
// Description : Directed self-checking bench for w_cpu_io_stream_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w_cpu_io_stream_bridge;

    logic        UserCLK = 1'b0;
    logic        reset;
    logic [31:0] cpu_op_data;
    logic        cpu_op_valid;
    logic        cpu_op_ready;
    logic [31:0] cpu_res_data;
    logic        cpu_res_valid;
    logic        cpu_res_ready;
    logic        cpu_res_err;
    logic [3:0]  OPA_O;
    logic [3:0]  OPB_O;
    logic [3:0]  RES0_I;
    logic [3:0]  RES1_I;
    logic [3:0]  RES2_I;

    int checks   = 0;
    int failures = 0;

    logic [3:0] nib_dead [8] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
    logic [3:0] nib_conc [8] = '{4'hC, 4'h3, 4'hD, 4'h2, 4'hE, 4'h1, 4'hF, 4'h0};
    logic [7:0] rx_conc  [4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};

    always #5 UserCLK = ~UserCLK;

    w_cpu_io_stream_bridge dut (
        .UserCLK       (UserCLK),
        .reset         (reset),
        .cpu_op_data   (cpu_op_data),
        .cpu_op_valid  (cpu_op_valid),
        .cpu_op_ready  (cpu_op_ready),
        .cpu_res_data  (cpu_res_data),
        .cpu_res_valid (cpu_res_valid),
        .cpu_res_ready (cpu_res_ready),
        .cpu_res_err   (cpu_res_err),
        .OPA_O         (OPA_O),
        .OPB_O         (OPB_O),
        .RES0_I        (RES0_I),
        .RES1_I        (RES1_I),
        .RES2_I        (RES2_I)
    );

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RES2_I layout: [0] op_ack, [1] res_valid, [2] res_last
    task automatic rx_drive(input logic vld, input logic last, input logic [7:0] b, input logic ack);
        RES0_I = b[3:0];
        RES1_I = b[7:4];
        RES2_I = {1'b0, last, vld, ack};
    endtask

    initial begin
        reset = 1'b1; cpu_op_data = '0; cpu_op_valid = 1'b0; cpu_res_ready = 1'b0;
        rx_drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick(); tick();
        chk("rst_op_ready", {31'b0, cpu_op_ready}, 32'd0);
        chk("rst_opb", {28'b0, OPB_O}, 32'd0);
        chk("rst_opa", {28'b0, OPA_O}, 32'd0);
        chk("rst_res_valid", {31'b0, cpu_res_valid}, 32'd0);
        chk("rst_res_data", cpu_res_data, 32'd0);
        chk("rst_res_err", {31'b0, cpu_res_err}, 32'd0);

        reset = 1'b0;
        tick();
        chk("post_rst_op_ready", {31'b0, cpu_op_ready}, 32'd1);
        chk("post_rst_opb", {28'b0, OPB_O}, 32'h8);

        // Word 0x87654321, ack every cycle
        cpu_op_data = 32'h8765_4321; cpu_op_valid = 1'b1;
        tick();
        cpu_op_valid = 1'b0;
        chk("w1_beat0_opa", {28'b0, OPA_O}, 32'd1);
        chk("w1_beat0_ctrl", {29'b0, OPB_O[2:0]}, 32'h3);
        chk("w1_busy_ready", {31'b0, cpu_op_ready}, 32'd0);
        RES2_I[0] = 1'b1;
        for (int b = 1; b < 8; b++) begin
            tick();
            chk("w1_opa", {28'b0, OPA_O}, 32'(b + 1));
            chk("w1_ctrl", {29'b0, OPB_O[2:0]}, (b == 7) ? 32'h5 : 32'h1);
        end
        tick();
        RES2_I[0] = 1'b0;
        chk("w1_done_ready", {31'b0, cpu_op_ready}, 32'd1);
        chk("w1_done_ctrl", {29'b0, OPB_O[2:0]}, 32'd0);
        chk("w1_done_opa", {28'b0, OPA_O}, 32'd0);

        // Word 0xDEADBEEF, ack only every third cycle
        cpu_op_data = 32'hDEAD_BEEF; cpu_op_valid = 1'b1;
        tick();
        cpu_op_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            tick(); tick();
            chk("w2_held_opa", {28'b0, OPA_O}, {28'b0, nib_dead[b]});
            chk("w2_held_valid", {31'b0, OPB_O[0]}, 32'd1);
            RES2_I[0] = 1'b1;
            tick();
            RES2_I[0] = 1'b0;
        end
        chk("w2_done_ready", {31'b0, cpu_op_ready}, 32'd1);

        // Clean 4-byte result, CPU stalls 5 cycles
        rx_drive(1'b1, 1'b0, 8'h44, 1'b0); tick();
        rx_drive(1'b1, 1'b0, 8'h33, 1'b0); tick();
        rx_drive(1'b1, 1'b0, 8'h22, 1'b0); tick();
        rx_drive(1'b1, 1'b1, 8'h11, 1'b0); tick();
        rx_drive(1'b1, 1'b1, 8'hFF, 1'b0);
        chk("r1_valid", {31'b0, cpu_res_valid}, 32'd1);
        chk("r1_data", cpu_res_data, 32'h1122_3344);
        chk("r1_err", {31'b0, cpu_res_err}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        rx_drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("r1_hold_data", cpu_res_data, 32'h1122_3344);
        chk("r1_hold_ready", {31'b0, OPB_O[3]}, 32'd0);
        cpu_res_ready = 1'b1;
        tick();
        cpu_res_ready = 1'b0;
        chk("r1_cleared_valid", {31'b0, cpu_res_valid}, 32'd0);
        chk("r1_cleared_data", cpu_res_data, 32'd0);
        chk("r1_collect_ready", {31'b0, OPB_O[3]}, 32'd1);

        // Short result: last on second byte
        rx_drive(1'b1, 1'b0, 8'hAA, 1'b0); tick();
        rx_drive(1'b1, 1'b1, 8'hBB, 1'b0); tick();
        rx_drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("r2_data", cpu_res_data, 32'h0000_BBAA);
        chk("r2_err", {31'b0, cpu_res_err}, 32'd1);
        cpu_res_ready = 1'b1; tick(); cpu_res_ready = 1'b0;
        chk("r2_cleared_err", {31'b0, cpu_res_err}, 32'd0);

        // Four bytes without res_last
        rx_drive(1'b1, 1'b0, 8'h01, 1'b0); tick();
        rx_drive(1'b1, 1'b0, 8'h02, 1'b0); tick();
        rx_drive(1'b1, 1'b0, 8'h03, 1'b0); tick();
        rx_drive(1'b1, 1'b0, 8'h04, 1'b0); tick();
        rx_drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("r3_data", cpu_res_data, 32'h0403_0201);
        chk("r3_err", {31'b0, cpu_res_err}, 32'd1);
        chk("r3_valid", {31'b0, cpu_res_valid}, 32'd1);
        cpu_res_ready = 1'b1; tick(); cpu_res_ready = 1'b0;

        // Concurrent TX word and RX result
        cpu_op_data = 32'h0F1E_2D3C; cpu_op_valid = 1'b1;
        rx_drive(1'b1, 1'b0, rx_conc[0], 1'b0);
        tick();
        cpu_op_valid = 1'b0;
        chk("c_beat0_opa", {28'b0, OPA_O}, 32'hC);
        for (int b = 1; b < 8; b++) begin
            if (b < 4) rx_drive(1'b1, b == 3, rx_conc[b], 1'b1);
            else       rx_drive(1'b0, 1'b0, 8'h00, 1'b1);
            tick();
            chk("c_opa", {28'b0, OPA_O}, {28'b0, nib_conc[b]});
        end
        chk("c_res_valid", {31'b0, cpu_res_valid}, 32'd1);
        chk("c_res_data", cpu_res_data, 32'h8D7C_6B5A);
        chk("c_res_err", {31'b0, cpu_res_err}, 32'd0);
        tick();
        RES2_I[0] = 1'b0;
        chk("c_tx_done_ready", {31'b0, cpu_op_ready}, 32'd1);
        cpu_res_ready = 1'b1; tick(); cpu_res_ready = 1'b0;

        // Reset in the middle of both paths
        cpu_op_data = 32'h7654_3210; cpu_op_valid = 1'b1;
        tick();
        cpu_op_valid = 1'b0;
        rx_drive(1'b1, 1'b0, 8'h99, 1'b1);
        tick();
        rx_drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick(); tick(); tick();
        chk("m_beat4_opa", {28'b0, OPA_O}, 32'd4);
        reset = 1'b1;
        RES2_I[0] = 1'b0;
        tick();
        chk("m_rst_valid", {31'b0, OPB_O[0]}, 32'd0);
        chk("m_rst_opa", {28'b0, OPA_O}, 32'd0);
        chk("m_rst_ready", {31'b0, cpu_op_ready}, 32'd0);
        chk("m_rst_res_data", cpu_res_data, 32'd0);
        reset = 1'b0;
        tick();
        chk("m_post_ready", {31'b0, cpu_op_ready}, 32'd1);
        chk("m_post_res_ready", {31'b0, OPB_O[3]}, 32'd1);
        cpu_op_data = 32'hA5A5_A5A5; cpu_op_valid = 1'b1;
        tick();
        cpu_op_valid = 1'b0;
        chk("m_new_opa", {28'b0, OPA_O}, 32'h5);
        chk("m_new_ctrl", {29'b0, OPB_O[2:0]}, 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
